// File: rtl/uart_hex_cmd_engine.sv
// ASCII hex command engine: parses R/W/? commands from a UART byte stream, runs one
// req/ack bus transaction per command and streams the ASCII reply back to the transmitter.
module uart_hex_cmd_engine #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_stb_i,
  input  logic [7:0]        rx_data_i,
  output logic              tx_stb_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_busy_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic [7:0]        err_cnt_o,
  output logic              busy_o
);

  localparam int NA    = ADDR_W / 4;
  localparam int ND    = DATA_W / 4;
  localparam int MAXD  = (NA > ND) ? NA : ND;
  localparam int CNT_W = $clog2(MAXD + 1) + 1;
  localparam int IDX_W = $clog2(ND + 2);
  localparam int TMO_W = $clog2(TIMEOUT);

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] SP = 8'h20;

  typedef enum logic [3:0] {
    S_IDLE, S_QRY, S_ADDR, S_SEP, S_DATA, S_EXEC, S_WAIT, S_RESP, S_DRAIN
  } state_e;

  typedef enum logic [1:0] {RSP_RD, RSP_OK, RSP_ER} resp_e;

  state_e            state_q;
  resp_e             resp_q;
  logic              we_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic              bus_we_q;
  logic              req_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [DATA_W-1:0] rdata_q;
  logic [IDX_W-1:0]  idx_q;
  logic              tx_stb_q;
  logic [7:0]        tx_data_q;
  logic              err_evt_q;
  logic [7:0]        err_cnt_q;

  logic              rx_is_hex_d;
  logic [3:0]        rx_nib_d;
  logic              rx_is_cr_d;
  logic              rx_is_sp_d;
  logic              bad_d;
  logic              ovr_d;
  logic [8:0]        err_sum_d;
  logic [7:0]        resp_byte_d;
  logic [IDX_W-1:0]  last_idx_d;

  function automatic logic [7:0] hex2asc(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    rx_is_hex_d = 1'b0;
    rx_nib_d    = 4'd0;
    if (rx_data_i >= "0" && rx_data_i <= "9") begin
      rx_is_hex_d = 1'b1;
      rx_nib_d    = rx_data_i[3:0];
    end else if ((rx_data_i >= "A" && rx_data_i <= "F") ||
                 (rx_data_i >= "a" && rx_data_i <= "f")) begin
      rx_is_hex_d = 1'b1;
      rx_nib_d    = rx_data_i[3:0] + 4'd9;
    end
    rx_is_cr_d = (rx_data_i == CR);
    rx_is_sp_d = (rx_data_i == SP);
  end

  // A byte that breaks the grammar of the current parse state.
  always_comb begin
    bad_d = 1'b0;
    case (state_q)
      S_IDLE: bad_d = !(rx_data_i inside {"R", "r", "W", "w", "?", CR, LF, SP});
      S_QRY:  bad_d = !rx_is_cr_d;
      S_ADDR: begin
        if (rx_is_hex_d)     bad_d = (cnt_q == CNT_W'(NA));
        else if (rx_is_cr_d) bad_d = we_q || (cnt_q != CNT_W'(NA));
        else if (rx_is_sp_d) bad_d = !we_q || (cnt_q != CNT_W'(NA));
        else                 bad_d = 1'b1;
      end
      S_SEP:  bad_d = !(rx_is_sp_d || rx_is_hex_d);
      S_DATA: begin
        if (rx_is_hex_d)     bad_d = (cnt_q == CNT_W'(ND));
        else if (rx_is_cr_d) bad_d = (cnt_q != CNT_W'(ND));
        else                 bad_d = 1'b1;
      end
      default: bad_d = 1'b0;
    endcase
  end

  assign ovr_d     = rx_stb_i && (state_q inside {S_EXEC, S_WAIT, S_RESP});
  assign err_sum_d = {1'b0, err_cnt_q} + {8'd0, err_evt_q} + {8'd0, ovr_d};

  // Response byte at idx_q; read data is consumed from the top nibble of a shifting copy.
  always_comb begin
    resp_byte_d = 8'h00;
    last_idx_d  = (resp_q == RSP_RD) ? IDX_W'(ND + 1) : IDX_W'(3);
    if (resp_q == RSP_RD) begin
      if (idx_q < IDX_W'(ND))       resp_byte_d = hex2asc(rdata_q[DATA_W-1 -: 4]);
      else if (idx_q == IDX_W'(ND)) resp_byte_d = CR;
      else                          resp_byte_d = LF;
    end else begin
      if (idx_q == IDX_W'(0))       resp_byte_d = (resp_q == RSP_OK) ? "O" : "E";
      else if (idx_q == IDX_W'(1))  resp_byte_d = (resp_q == RSP_OK) ? "K" : "R";
      else if (idx_q == IDX_W'(2))  resp_byte_d = CR;
      else                          resp_byte_d = LF;
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every read in
  // this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      resp_q      <= RSP_OK;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_we_q    <= 1'b0;
      req_q       <= 1'b0;
      tmo_q       <= '0;
      rdata_q     <= '0;
      idx_q       <= '0;
      tx_stb_q    <= 1'b0;
      tx_data_q   <= 8'h00;
      err_evt_q   <= 1'b0;
      err_cnt_q   <= 8'h00;
    end else begin
      tx_stb_q  <= 1'b0;
      err_evt_q <= 1'b0;
      err_cnt_q <= err_sum_d[8] ? 8'hFF : err_sum_d[7:0];

      if (rx_stb_i && bad_d) begin
        // A bad CR ends the command at once; anything else drains up to the next CR.
        state_q   <= rx_is_cr_d ? S_RESP : S_DRAIN;
        resp_q    <= RSP_ER;
        idx_q     <= '0;
        err_evt_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: if (rx_stb_i) begin
            cnt_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            if (rx_data_i inside {"R", "r"}) begin
              we_q    <= 1'b0;
              state_q <= S_ADDR;
            end else if (rx_data_i inside {"W", "w"}) begin
              we_q    <= 1'b1;
              state_q <= S_ADDR;
            end else if (rx_data_i == "?") begin
              state_q <= S_QRY;
            end
          end
          S_QRY: if (rx_stb_i) begin
            state_q <= S_RESP;
            resp_q  <= RSP_OK;
            idx_q   <= '0;
          end
          S_ADDR: if (rx_stb_i) begin
            if (rx_is_hex_d) begin
              addr_q <= (addr_q << 4) | ADDR_W'(rx_nib_d);
              cnt_q  <= cnt_q + CNT_W'(1);
            end else if (rx_is_cr_d) begin
              bus_addr_q <= addr_q;
              bus_we_q   <= 1'b0;
              state_q    <= S_EXEC;
            end else begin
              cnt_q   <= '0;
              state_q <= S_SEP;
            end
          end
          S_SEP: if (rx_stb_i && rx_is_hex_d) begin
            data_q  <= DATA_W'(rx_nib_d);
            cnt_q   <= CNT_W'(1);
            state_q <= S_DATA;
          end
          S_DATA: if (rx_stb_i) begin
            if (rx_is_hex_d) begin
              data_q <= (data_q << 4) | DATA_W'(rx_nib_d);
              cnt_q  <= cnt_q + CNT_W'(1);
            end else begin
              bus_addr_q  <= addr_q;
              bus_wdata_q <= data_q;
              bus_we_q    <= 1'b1;
              state_q     <= S_EXEC;
            end
          end
          S_EXEC: begin
            req_q   <= 1'b1;
            tmo_q   <= '0;
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            if (bus_ack_i) begin
              req_q   <= 1'b0;
              rdata_q <= bus_rdata_i;
              resp_q  <= bus_we_q ? RSP_OK : RSP_RD;
              idx_q   <= '0;
              state_q <= S_RESP;
            end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
              req_q     <= 1'b0;
              resp_q    <= RSP_ER;
              idx_q     <= '0;
              err_evt_q <= 1'b1;
              state_q   <= S_RESP;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
          S_RESP: if (!tx_busy_i && !tx_stb_q) begin
            tx_stb_q  <= 1'b1;
            tx_data_q <= resp_byte_d;
            if (resp_q == RSP_RD && idx_q < IDX_W'(ND)) rdata_q <= rdata_q << 4;
            if (idx_q == last_idx_d) state_q <= S_IDLE;
            else                     idx_q   <= idx_q + IDX_W'(1);
          end
          S_DRAIN: if (rx_stb_i && rx_is_cr_d) begin
            resp_q  <= RSP_ER;
            idx_q   <= '0;
            state_q <= S_RESP;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign tx_stb_o    = tx_stb_q;
  assign tx_data_o   = tx_data_q;
  assign bus_req_o   = req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign err_cnt_o   = err_cnt_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_hex_cmd_engine.sv
// Scoreboard bench for uart_hex_cmd_engine: expected TX bytes and bus transactions are queued
// by the stimulus and popped by independent monitors when the DUT produces them.
module tb_uart_hex_cmd_engine;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32/32 instance
  logic        rx_stb = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_stb, tx_busy;
  logic [7:0]  tx_data;
  logic        req, we, ack = 1'b0;
  logic [31:0] addr, wdata;
  logic [31:0] rdata = 32'hDEADBEEF;
  logic [7:0]  err_cnt;
  logic        busy;

  // 16/8 instance
  logic        rx_stb2 = 1'b0;
  logic [7:0]  rx_data2 = 8'h00;
  logic        tx_stb2, tx_busy2;
  logic [7:0]  tx_data2;
  logic        req2, we2, ack2 = 1'b0;
  logic [15:0] addr2;
  logic [7:0]  wdata2;
  logic [7:0]  rdata2 = 8'h3C;
  logic [7:0]  err_cnt2;
  logic        busy2;

  uart_hex_cmd_engine #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_stb_i(rx_stb), .rx_data_i(rx_data),
    .tx_stb_o(tx_stb), .tx_data_o(tx_data), .tx_busy_i(tx_busy),
    .bus_req_o(req), .bus_we_o(we), .bus_addr_o(addr), .bus_wdata_o(wdata),
    .bus_rdata_i(rdata), .bus_ack_i(ack), .err_cnt_o(err_cnt), .busy_o(busy)
  );

  uart_hex_cmd_engine #(.ADDR_W(16), .DATA_W(8), .TIMEOUT(1024)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .rx_stb_i(rx_stb2), .rx_data_i(rx_data2),
    .tx_stb_o(tx_stb2), .tx_data_o(tx_data2), .tx_busy_i(tx_busy2),
    .bus_req_o(req2), .bus_we_o(we2), .bus_addr_o(addr2), .bus_wdata_o(wdata2),
    .bus_rdata_i(rdata2), .bus_ack_i(ack2), .err_cnt_o(err_cnt2), .busy_o(busy2)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } txn_t;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_tx2[$];
  txn_t       exp_txn[$];
  bit         mon_en = 1'b1;
  bit         ack_en = 1'b1;

  // Transmitter models: busy rises the cycle after a strobe and lasts three cycles.
  logic [1:0] busy_cnt = '0, busy_cnt2 = '0;
  always @(posedge clk) begin
    if (tx_stb) busy_cnt <= 2'd3;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 2'd1;
    if (tx_stb2) busy_cnt2 <= 2'd3;
    else if (busy_cnt2 != 0) busy_cnt2 <= busy_cnt2 - 2'd1;
  end
  assign tx_busy  = (busy_cnt != 0);
  assign tx_busy2 = (busy_cnt2 != 0);

  // Bus models: main instance acks 3 cycles into the request, second one after 1 cycle.
  int req_cnt = 0;
  always @(posedge clk) begin
    ack <= 1'b0;
    if (req && ack_en && !ack) begin
      if (req_cnt == 2) begin
        ack     <= 1'b1;
        req_cnt <= 0;
      end else begin
        req_cnt <= req_cnt + 1;
      end
    end else if (!req) begin
      req_cnt <= 0;
    end
    ack2 <= req2 && !ack2;
  end

  // TX monitors
  always @(negedge clk) begin
    if (rst_n && mon_en && tx_stb) begin
      if (exp_tx.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_extra actual=%02h expected=none", tx_data);
      end else begin
        check("tx_byte", tx_data, exp_tx.pop_front());
      end
    end
    if (rst_n && tx_stb2) begin
      if (exp_tx2.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx2_extra actual=%02h expected=none", tx_data2);
      end else begin
        check("tx2_byte", tx_data2, exp_tx2.pop_front());
      end
    end
  end

  // Bus monitors: transaction contents at request rise, request length at fall.
  logic req_prev = 1'b0, req2_prev = 1'b0;
  int   req_len = 0, last_req_len = 0;
  always @(negedge clk) begin
    req_prev  <= req;
    req2_prev <= req2;
    if (req && !req_prev) begin
      if (exp_txn.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL bus_extra actual_addr=%08h expected=none", addr);
      end else begin
        txn_t t;
        t = exp_txn.pop_front();
        check("bus_addr", addr, t.addr);
        check("bus_we", we, t.we);
        if (t.we) check("bus_wdata", wdata, t.wdata);
      end
    end
    if (req) req_len <= req_len + 1;
    else if (req_prev) begin
      last_req_len <= req_len;
      req_len      <= 0;
    end
    if (req2 && !req2_prev) begin
      check("bus2_addr", addr2, 16'h00FF);
      check("bus2_we", we2, 1'b0);
    end
  end

  task automatic push_str(input string s, input bit sel);
    for (int i = 0; i < s.len(); i++) begin
      if (sel) exp_tx2.push_back(s[i]);
      else     exp_tx.push_back(s[i]);
    end
  endtask

  task automatic push_txn(input logic [31:0] a, input logic w, input logic [31:0] d);
    txn_t t;
    t.addr = a;
    t.we = w;
    t.wdata = d;
    exp_txn.push_back(t);
  endtask

  task automatic send(input string s, input bit sel);
    for (int i = 0; i < s.len(); i++) begin
      @(posedge clk); #1;
      if (sel) begin rx_stb2 = 1'b1; rx_data2 = s[i]; end
      else     begin rx_stb  = 1'b1; rx_data  = s[i]; end
      @(posedge clk); #1;
      rx_stb  = 1'b0;
      rx_stb2 = 1'b0;
    end
  endtask

  task automatic wait_done(input string name, input bit sel);
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (sel) done = (exp_tx2.size() == 0) && !busy2;
      else     done = (exp_tx.size() == 0) && !busy;
    end
    check({name, "_done"}, done, 1'b1);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_ctl"}, {tx_stb, tx_data, req, we, busy, err_cnt}, 0);
    check({name, "_addr"}, addr, 0);
    check({name, "_wdata"}, wdata, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Read, all digits of one value
    push_txn(32'hAAAAAAAA, 1'b0, 32'h0);
    push_str("DEADBEEF\015\012", 1'b0);
    send("RAAAAAAAA\015", 1'b0);
    wait_done("read", 1'b0);
    check("read_err", err_cnt, 0);

    // Write, lowercase command and hex
    push_txn(32'h12345678, 1'b1, 32'h89ABCDEF);
    push_str("OK\015\012", 1'b0);
    send("w12345678 89abcdef\015", 1'b0);
    wait_done("write", 1'b0);
    check("write_err", err_cnt, 0);

    // Too few digits, bad command, one digit too many
    push_str("ER\015\012", 1'b0);
    send("R1234\015", 1'b0);
    wait_done("short", 1'b0);
    check("short_err", err_cnt, 1);
    push_str("ER\015\012", 1'b0);
    send("X\015", 1'b0);
    wait_done("badcmd", 1'b0);
    check("badcmd_err", err_cnt, 2);
    push_str("ER\015\012", 1'b0);
    send("R123456789\015", 1'b0);
    wait_done("long", 1'b0);
    check("long_err", err_cnt, 3);

    // Bus never acks
    ack_en = 1'b0;
    push_txn(32'h00000010, 1'b0, 32'h0);
    push_str("ER\015\012", 1'b0);
    send("r00000010\015", 1'b0);
    wait_done("timeout", 1'b0);
    check("timeout_len", last_req_len, TMO);
    check("timeout_err", err_cnt, 4);
    ack_en = 1'b1;

    // Overrun byte during the response
    push_str("OK\015\012", 1'b0);
    send("?\015t", 1'b0);
    wait_done("overrun", 1'b0);
    check("overrun_err", err_cnt, 5);
    push_str("OK\015\012", 1'b0);
    send("?\015", 1'b0);
    wait_done("query", 1'b0);
    check("query_err", err_cnt, 5);

    // Reset in the middle of WAIT
    ack_en = 1'b0;
    push_txn(32'h00000004, 1'b0, 32'h0);
    send("R00000004\015", 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = req;
    end
    check("wait_req_seen", seen, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("rst_wait");
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    ack_en = 1'b1;
    repeat (30) @(negedge clk);
    check("rst_wait_idle", {busy, req}, 0);

    // Reset in the middle of RESP: first byte goes out unchecked, nothing after reset
    mon_en = 1'b0;
    send("?\015", 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = tx_stb;
    end
    check("resp_stb_seen", seen, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("rst_resp");
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_resp_idle", {busy, err_cnt}, 0);

    push_str("OK\015\012", 1'b0);
    send("?\015", 1'b0);
    wait_done("post_reset", 1'b0);

    // Narrow instance: 16-bit address, 8-bit data
    push_str("3C\015\012", 1'b1);
    send("R00FF\015", 1'b1);
    wait_done("narrow", 1'b1);
    check("narrow_err", err_cnt2, 0);

    check("txn_all_seen", exp_txn.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
